// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the multi-channel UART transmitter.
//   tx_state_t           : transmit FSM states (IDLE, START, DATA, STOP)
//   PRIO_RR / PRIO_FIXED : arbitration mode selectors
//   CLKS_PER_BIT_115200  : bit period for 115200 baud at 100 MHz
//   clog2()              : ceiling log2, used to size counters
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int PRIO_RR             = 0;
  localparam int PRIO_FIXED          = 1;
  localparam int CLKS_PER_BIT_115200 = 868;

  // Ceiling log2; returns 0 for n <= 1, so callers clamp widths to >= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational request arbiter.
//   MODE = PRIO_RR    : search starts at pointer+1 and wraps around
//   MODE = PRIO_FIXED : lowest set index wins, pointer ignored
// Ports:
//   req     in  NUM_CH  request vector
//   pointer in  IDX_W   index of the last winner (round-robin only)
//   enable  in  1       when low no grant is issued
//   grant   out NUM_CH  one-hot winner (all zero when nothing wins)
//   index   out IDX_W   binary index of the winner
// -----------------------------------------------------------------------------
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MODE   = PRIO_RR,
  parameter int IDX_W  = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  pointer,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  index
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Candidates are visited in priority order; the first requesting one wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (MODE == PRIO_FIXED) begin
        cand = IDX_W'(k);
      end else begin
        cand = IDX_W'((32'(pointer) + k + 1) % NUM_CH);
      end
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Multi-channel UART transmitter: arbitrates NUM_CH byte producers and
// serialises the winner onto one TXD line (start, DATA_W bits LSB first,
// STOP_BITS stop bits). Frame starts can be gated by active-low CTS.
// Ports:
//   Clock          in  1              system clock
//   Reset          in  1              asynchronous active-low reset
//   Data           in  NUM_CH*DATA_W  channel i byte at [i*DATA_W +: DATA_W]
//   RequestToSend  in  NUM_CH         level request per channel
//   DataReceived   out NUM_CH         one-cycle ack: byte latched for channel
//   CtsN           in  1              clear-to-send, active-low, asynchronous
//   SDO            out 1              serial TXD, idle high
//   Busy           out 1              high from frame start to last stop bit
//   Grant          out NUM_CH         one-hot owner of the frame in flight
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 8,
  parameter int CLKS_PER_BIT  = CLKS_PER_BIT_115200,
  parameter int PRIORITY_MODE = PRIO_RR,
  parameter int STOP_BITS     = 1,
  parameter int USE_CTS       = 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NUM_CH*DATA_W-1:0] Data,
  input  logic [NUM_CH-1:0]        RequestToSend,
  output logic [NUM_CH-1:0]        DataReceived,
  input  logic                     CtsN,
  output logic                     SDO,
  output logic                     Busy,
  output logic [NUM_CH-1:0]        Grant
);

  localparam int IDX_W = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam int CNT_W = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
  localparam int BIT_W = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);

  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_W - 1);
  localparam logic             LAST_STOP   = 1'(STOP_BITS - 1);

  tx_state_t          state;
  logic [CNT_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic               stop_idx;
  logic [DATA_W-1:0]  shreg;
  logic               sdo_q;
  logic               busy_q;
  logic [NUM_CH-1:0]  grant_q;
  logic [NUM_CH-1:0]  ack_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic               cts_meta;
  logic               cts_sync;

  logic               start_ok;
  logic [NUM_CH-1:0]  win_grant;
  logic [IDX_W-1:0]   win_idx;
  logic [DATA_W-1:0]  win_data;

  // Requests are only considered in IDLE, so a held request cannot be
  // accepted twice for one frame.
  always_comb begin
    start_ok = 1'b0;
    if (state == IDLE && (|RequestToSend) && (USE_CTS == 0 || !cts_sync)) begin
      start_ok = 1'b1;
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (PRIORITY_MODE),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req     (RequestToSend),
    .pointer (rr_ptr),
    .enable  (start_ok),
    .grant   (win_grant),
    .index   (win_idx)
  );

  // One-hot AND-OR mux of the winning channel's byte.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      win_data = win_data | (Data[i*DATA_W +: DATA_W] & {DATA_W{win_grant[i]}});
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      sdo_q    <= 1'b1;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      ack_q    <= '0;
      rr_ptr   <= IDX_W'(NUM_CH - 1);
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= CtsN;
      cts_sync <= cts_meta;
      ack_q    <= '0;

      unique case (state)
        IDLE: begin
          sdo_q   <= 1'b1;
          busy_q  <= 1'b0;
          grant_q <= '0;
          if (start_ok) begin
            shreg    <= win_data;
            ack_q    <= win_grant;
            grant_q  <= win_grant;
            busy_q   <= 1'b1;
            sdo_q    <= 1'b0;
            baud_cnt <= BAUD_RELOAD;
            state    <= START;
            if (PRIORITY_MODE == PRIO_RR) begin
              rr_ptr <= win_idx;
            end
          end
        end

        START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            sdo_q    <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == LAST_BIT) begin
              sdo_q    <= 1'b1;
              stop_idx <= 1'b0;
              state    <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              sdo_q   <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == '0) begin
            if (stop_idx == LAST_STOP) begin
              // Leaving STOP guarantees one IDLE cycle with SDO high
              // before any following start bit.
              busy_q  <= 1'b0;
              grant_q <= '0;
              sdo_q   <= 1'b1;
              state   <= IDLE;
            end else begin
              stop_idx <= 1'b1;
              baud_cnt <= BAUD_RELOAD;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign SDO          = sdo_q;
  assign Busy         = busy_q;
  assign Grant        = grant_q;
  assign DataReceived = ack_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with three configurations:
//   u_rr : round-robin, 4 channels, 8 data bits, 4 clocks/bit, CTS used
//   u_fx : fixed priority, otherwise as u_rr
//   u_s2 : 7 data bits, 2 stop bits, CTS ignored
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cts_n = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] rr_data = '0;
  logic [3:0]  rr_rts = '0;
  logic [3:0]  rr_ack;
  logic        rr_sdo;
  logic        rr_busy;
  logic [3:0]  rr_grant;

  logic [31:0] fx_data = '0;
  logic [3:0]  fx_rts = '0;
  logic [3:0]  fx_ack;
  logic        fx_sdo;
  logic        fx_busy;
  logic [3:0]  fx_grant;

  logic [27:0] s2_data = '0;
  logic [3:0]  s2_rts = '0;
  logic [3:0]  s2_ack;
  logic        s2_sdo;
  logic        s2_busy;
  logic [3:0]  s2_grant;

  uart_tx_arbiter #(
    .NUM_CH(4), .DATA_W(8), .CLKS_PER_BIT(4),
    .PRIORITY_MODE(0), .STOP_BITS(1), .USE_CTS(1)
  ) u_rr (
    .Clock(clk), .Reset(rst_n), .Data(rr_data), .RequestToSend(rr_rts),
    .DataReceived(rr_ack), .CtsN(cts_n), .SDO(rr_sdo), .Busy(rr_busy),
    .Grant(rr_grant)
  );

  uart_tx_arbiter #(
    .NUM_CH(4), .DATA_W(8), .CLKS_PER_BIT(4),
    .PRIORITY_MODE(1), .STOP_BITS(1), .USE_CTS(1)
  ) u_fx (
    .Clock(clk), .Reset(rst_n), .Data(fx_data), .RequestToSend(fx_rts),
    .DataReceived(fx_ack), .CtsN(cts_n), .SDO(fx_sdo), .Busy(fx_busy),
    .Grant(fx_grant)
  );

  uart_tx_arbiter #(
    .NUM_CH(4), .DATA_W(7), .CLKS_PER_BIT(4),
    .PRIORITY_MODE(0), .STOP_BITS(2), .USE_CTS(0)
  ) u_s2 (
    .Clock(clk), .Reset(rst_n), .Data(s2_data), .RequestToSend(s2_rts),
    .DataReceived(s2_ack), .CtsN(cts_n), .SDO(s2_sdo), .Busy(s2_busy),
    .Grant(s2_grant)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset all instances, then allow the CTS synchroniser to settle.
  task automatic do_reset;
    rr_rts = '0;
    fx_rts = '0;
    s2_rts = '0;
    rst_n  = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    repeat (3) tick;
  endtask

  // Test 2 bookkeeping
  logic [3:0] ack_seen [5];
  logic [3:0] grant_at [5];
  int         ack_cyc  [5];
  logic       idle_before [5];
  logic [7:0] got_b    [4];
  logic [7:0] ch_byte  [4];
  int         n;
  int         since;
  logic [7:0] rxb;
  logic       prev_busy;

  logic [9:0] bits;
  int         cnt_a;
  int         cnt_b;
  int         first_d;
  logic [3:0] first_ack;
  logic [3:0] first_grant;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    // ---------------- Test 1: reset state, single 0xA5 frame ----------------
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_sdo",   32'(rr_sdo),   1);
    check("rst_busy",  32'(rr_busy),  0);
    check("rst_grant", 32'(rr_grant), 0);
    check("rst_ack",   32'(rr_ack),   0);
    tick;
    tick;
    rst_n = 1'b1;
    repeat (3) tick;

    rr_data[7:0] = 8'hA5;
    rr_rts       = 4'b0001;
    tick;
    check("t1_ack_pulse", 32'(rr_ack), 1);
    rr_rts = '0;
    bits   = 10'b1101001010;
    cnt_a  = 0;
    for (int c = 0; c < 40; c++) begin
      if (rr_ack != 4'b0000) cnt_a++;
      check("t1_sdo",   32'(rr_sdo),   32'(bits[0]));
      check("t1_busy",  32'(rr_busy),  1);
      check("t1_grant", 32'(rr_grant), 1);
      if (c % 4 == 3) bits = bits >> 1;
      tick;
    end
    check("t1_ack_count", cnt_a, 1);
    check("t1_end_busy",  32'(rr_busy),  0);
    check("t1_end_sdo",   32'(rr_sdo),   1);
    check("t1_end_grant", 32'(rr_grant), 0);

    // ---------------- Test 2: round-robin, all channels held ----------------
    do_reset;
    ch_byte[0] = 8'h3C;
    ch_byte[1] = 8'hC1;
    ch_byte[2] = 8'h5A;
    ch_byte[3] = 8'h96;
    rr_data = {ch_byte[3], ch_byte[2], ch_byte[1], ch_byte[0]};
    rr_rts  = 4'b1111;
    n         = 0;
    since     = 0;
    rxb       = '0;
    prev_busy = rr_busy;
    for (int c = 0; c < 260 && n < 5; c++) begin
      tick;
      if (rr_ack != 4'b0000) begin
        if (n > 0) got_b[n-1] = rxb;
        ack_seen[n]    = rr_ack;
        grant_at[n]    = rr_grant;
        ack_cyc[n]     = c;
        idle_before[n] = prev_busy;
        n++;
        since = 0;
        rxb   = '0;
      end else begin
        since++;
        if (since >= 6 && since <= 34 && since % 4 == 2) rxb = {rr_sdo, rxb[7:1]};
      end
      prev_busy = rr_busy;
    end
    check("t2_ack_count", n, 5);
    for (int k = 0; k < 5; k++) begin
      if (k < n) begin
        check("t2_ack_order", 32'(ack_seen[k]), 1 << (k % 4));
        check("t2_grant",     32'(grant_at[k]), 1 << (k % 4));
        check("t2_idle_gap",  32'(idle_before[k]), 0);
        if (k > 0) check("t2_spacing", ack_cyc[k] - ack_cyc[k-1], 41);
        if (k < 4) check("t2_byte", 32'(got_b[k]), 32'(ch_byte[k]));
      end
    end
    rr_rts = '0;
    repeat (45) tick;

    // ---------------- Test 3: fixed priority ----------------
    cts_n = 1'b0;
    do_reset;
    fx_data = {8'h44, 8'h22, 8'h11, 8'h00};
    fx_rts  = 4'b0110;
    cnt_a   = 0;
    cnt_b   = 0;
    for (int c = 0; c < 124; c++) begin
      tick;
      if (fx_ack == 4'b0010) cnt_a++;
      else if (fx_ack != 4'b0000) cnt_b++;
    end
    check("t3_ch1_acks",   cnt_a, 4);
    check("t3_other_acks", cnt_b, 0);
    fx_rts      = 4'b0100;
    first_d     = -1;
    first_ack   = '0;
    first_grant = '0;
    for (int d = 1; d <= 60; d++) begin
      tick;
      if (first_d < 0 && fx_ack != 4'b0000) begin
        first_d     = d;
        first_ack   = fx_ack;
        first_grant = fx_grant;
      end
    end
    check("t3_ch2_ack",   32'(first_ack),   4);
    check("t3_ch2_grant", 32'(first_grant), 4);
    check("t3_ch2_delay", first_d, 41);
    fx_rts = '0;
    repeat (45) tick;

    // ---------------- Test 4: CTS gating ----------------
    cts_n = 1'b1;
    do_reset;
    rr_data[7:0] = 8'h0F;
    rr_rts       = 4'b0001;
    cnt_a        = 0;
    for (int c = 0; c < 100; c++) begin
      tick;
      if (rr_sdo == 1'b0 || rr_busy == 1'b1 || rr_ack != 4'b0000) cnt_a++;
    end
    check("t4_held_off", cnt_a, 0);
    cts_n = 1'b0;
    tick;
    check("t4_sync1_sdo", 32'(rr_sdo), 1);
    tick;
    check("t4_sync2_sdo", 32'(rr_sdo), 1);
    tick;
    check("t4_start_sdo", 32'(rr_sdo), 0);
    check("t4_start_ack", 32'(rr_ack), 1);
    cnt_b = 0;
    for (int c = 1; c < 40; c++) begin
      tick;
      if (c == 12) cts_n = 1'b1;
      if (rr_busy != 1'b1) cnt_b++;
    end
    check("t4_frame_completes", cnt_b, 0);
    tick;
    check("t4_end_busy", 32'(rr_busy), 0);
    cnt_a = 0;
    for (int c = 0; c < 60; c++) begin
      tick;
      if (rr_sdo == 1'b0 || rr_busy == 1'b1 || rr_ack != 4'b0000) cnt_a++;
    end
    check("t4_next_held", cnt_a, 0);
    rr_rts = '0;

    // ---------------- Test 5: reset mid data bit 3 ----------------
    cts_n = 1'b0;
    do_reset;
    rr_data[7:0] = 8'h00;
    rr_rts       = 4'b0001;
    tick;
    check("t5_start_ack", 32'(rr_ack), 1);
    rr_rts = '0;
    repeat (17) tick;
    check("t5_bit3_sdo",  32'(rr_sdo),  0);
    check("t5_bit3_busy", 32'(rr_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_sdo",   32'(rr_sdo),   1);
    check("t5_rst_busy",  32'(rr_busy),  0);
    check("t5_rst_grant", 32'(rr_grant), 0);
    rr_rts = 4'b1010;
    #2;
    rst_n       = 1'b1;
    first_d     = -1;
    first_ack   = '0;
    first_grant = '0;
    for (int d = 1; d <= 10; d++) begin
      tick;
      if (first_d < 0 && rr_ack != 4'b0000) begin
        first_d     = d;
        first_ack   = rr_ack;
        first_grant = rr_grant;
      end
    end
    check("t5_first_ack",   32'(first_ack),   2);
    check("t5_first_grant", 32'(first_grant), 2);
    check("t5_first_delay", first_d, 3);
    rr_rts = '0;
    repeat (45) tick;

    // ---------------- Test 6: 7 data bits, 2 stop bits, CTS ignored ----------------
    cts_n = 1'b1;
    do_reset;
    s2_data[6:0] = 7'h55;
    s2_rts       = 4'b0001;
    tick;
    check("t6_ack", 32'(s2_ack), 1);
    s2_rts = '0;
    bits   = 10'b1110101010;
    for (int c = 0; c < 40; c++) begin
      check("t6_sdo",  32'(s2_sdo),  32'(bits[0]));
      check("t6_busy", 32'(s2_busy), 1);
      if (c % 4 == 3) bits = bits >> 1;
      tick;
    end
    check("t6_end_busy",  32'(s2_busy),  0);
    check("t6_end_sdo",   32'(s2_sdo),   1);
    check("t6_end_grant", 32'(s2_grant), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
